// File: rtl/bft_pkg.sv
// Shared definitions for the deflection BFT: packet width helper,
// valid/flag bit positions and root slot-priority mode encodings.
package bft_pkg;

    // Slot priority modes for the buffered root stage
    localparam int MODE_RECIRC_FIRST = 0;
    localparam int MODE_INJ_FIRST    = 1;

    // Bit positions counted down from the packet MSB: valid = P_W-1, flag = P_W-2
    localparam int VALID_OFS = 1;
    localparam int FLAG_OFS  = 2;

    function automatic int pkt_width(input int a_w, input int d_w);
        return a_w + d_w + 2;
    endfunction

endpackage

// File: rtl/bft_root_fifo.sv
// Per-channel recirculation FIFO for the BFT root stage.
// DEPTH entries, occupancy output, and bypass: when empty, a push and a pop
// in the same cycle hand the pushed word straight to o_head without storing it.
module bft_root_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_ce,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH):0]     o_occ,
    output logic                       o_ovf_evt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [OCC_W-1:0] r_occ;

    logic w_empty;
    logic w_full;
    logic w_bypass;
    logic w_do_push;
    logic w_do_pop;

    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == OCC_W'(DEPTH));
    assign w_bypass  = w_empty & i_push & i_pop;
    assign w_do_push = i_ce & i_push & ~w_bypass & ~(w_full & ~i_pop);
    assign w_do_pop  = i_ce & i_pop & ~w_empty;

    assign o_head    = w_empty ? i_push_data : r_mem[r_rd_ptr];
    assign o_occ     = r_occ;
    // A push into a full FIFO with no matching pop would lose a packet
    assign o_ovf_evt = i_ce & i_push & w_full & ~i_pop;

    // Storage array; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (!rst && w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes all entries
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_occ <= r_occ + OCC_W'(w_do_push) - OCC_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/bft_root_buf.sv
// Buffered root stage of the deflection BFT. Up-going root ports recirculate
// through per-channel FIFOs to the down-going root ports; one external
// injection port (valid/ready) claims free slots round-robin.
// Optional statistics counters are built only when BFT_ROOT_STATS_EN is
// defined; otherwise inj_cnt and recirc_cnt are tied to zero.
// A reset mid-traffic flushes every FIFO; queued packets are discarded.
module bft_root_buf
    import bft_pkg::*;
#(
    parameter int CH    = 32,
    parameter int D_W   = 32,
    parameter int A_W   = $clog2(CH) + 1,
    parameter int P_W   = pkt_width(A_W, D_W),
    parameter int DEPTH = 4,
    parameter int MODE  = MODE_RECIRC_FIRST
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic [P_W*CH-1:0]   up_i,
    output logic [P_W*CH-1:0]   dn_o,
    input  logic [P_W-1:0]      inj_i,
    input  logic                inj_valid,
    output logic                inj_ready,
    output logic                ovf,
    output logic [31:0]         inj_cnt,
    output logic [31:0]         recirc_cnt
);
    localparam int SEL_W = $clog2(CH);
    localparam int OCC_W = $clog2(DEPTH) + 1;
    localparam int V_IDX = P_W - VALID_OFS;

    logic [CH-1:0]     w_up_v;
    logic [CH-1:0]     w_avail;
    logic [CH-1:0]     w_elig;
    logic [CH-1:0]     w_pop;
    logic [CH-1:0]     w_ovf_evt;
    logic [CH-1:0]     w_inj_hit;
    logic [OCC_W-1:0]  w_occ  [CH];
    logic [P_W-1:0]    w_head [CH];
    logic [SEL_W-1:0]  w_sel;
    logic              w_any_elig;
    logic              w_hwm;
    logic              w_inj_fire;
    logic [P_W-1:0]    w_inj_pkt;

    logic [SEL_W-1:0]  r_rr;
    logic              r_ovf;
    logic [P_W*CH-1:0] r_dn;

    // Injected packets always leave with the valid bit set
    assign w_inj_pkt = inj_i | {1'b1, {(P_W-1){1'b0}}};

    for (genvar c = 0; c < CH; c++) begin : g_ch
        assign w_up_v[c]    = up_i[c*P_W + V_IDX];
        assign w_avail[c]   = (w_occ[c] != '0) | w_up_v[c];
        assign w_inj_hit[c] = w_inj_fire & (w_sel == SEL_W'(c));

        if (MODE == MODE_INJ_FIRST) begin : g_inj_first
            // The injected channel skips its pop; its arrival is queued instead
            assign w_elig[c] = 1'b1;
            assign w_pop[c]  = w_avail[c] & ~w_inj_hit[c];
        end else begin : g_recirc_first
            assign w_elig[c] = ~w_avail[c];
            assign w_pop[c]  = w_avail[c];
        end

        bft_root_fifo #(
            .W     (P_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .i_ce        (ce),
            .i_push      (w_up_v[c]),
            .i_push_data (up_i[c*P_W +: P_W]),
            .i_pop       (w_pop[c]),
            .o_head      (w_head[c]),
            .o_occ       (w_occ[c]),
            .o_ovf_evt   (w_ovf_evt[c])
        );
    end

    // Round-robin pick: first eligible channel at or after r_rr
    always_comb begin
        w_sel      = r_rr;
        w_any_elig = 1'b0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (w_elig[r_rr + SEL_W'(k)]) begin
                w_sel      = r_rr + SEL_W'(k);
                w_any_elig = 1'b1;
            end
        end
    end

    // High-water mark: any FIFO one short of full blocks injection
    always_comb begin
        w_hwm = 1'b0;
        for (int c = 0; c < CH; c++) begin
            w_hwm = w_hwm | (w_occ[c] >= OCC_W'(DEPTH - 1));
        end
    end

    assign inj_ready  = ce & ~rst & w_any_elig & ~w_hwm;
    assign w_inj_fire = inj_valid & inj_ready;

    // Output slots, round-robin pointer and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dn  <= '0;
            r_rr  <= '0;
            r_ovf <= 1'b0;
        end else if (ce) begin
            for (int c = 0; c < CH; c++) begin
                if (w_inj_hit[c])  r_dn[c*P_W +: P_W] <= w_inj_pkt;
                else if (w_pop[c]) r_dn[c*P_W +: P_W] <= w_head[c];
                else               r_dn[c*P_W +: P_W] <= '0;
            end
            if (w_inj_fire)  r_rr  <= w_sel + SEL_W'(1);
            if (|w_ovf_evt)  r_ovf <= 1'b1;
        end
    end

    assign dn_o = r_dn;
    assign ovf  = r_ovf;

`ifdef BFT_ROOT_STATS_EN
    logic [31:0]    r_inj_cnt;
    logic [31:0]    r_recirc_cnt;
    logic [SEL_W:0] w_pop_cnt;

    // Number of recirculated packets leaving this cycle
    always_comb begin
        w_pop_cnt = '0;
        for (int c = 0; c < CH; c++) begin
            w_pop_cnt = w_pop_cnt + (SEL_W + 1)'(w_pop[c]);
        end
    end

    // Free-running traffic counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inj_cnt    <= '0;
            r_recirc_cnt <= '0;
        end else if (ce) begin
            r_inj_cnt    <= r_inj_cnt + 32'(w_inj_fire);
            r_recirc_cnt <= r_recirc_cnt + 32'(w_pop_cnt);
        end
    end

    assign inj_cnt    = r_inj_cnt;
    assign recirc_cnt = r_recirc_cnt;
`else
    assign inj_cnt    = '0;
    assign recirc_cnt = '0;
`endif

endmodule

// File: tb/tb_bft_root_buf.sv
// Directed bench for bft_root_buf: one MODE 0 and one MODE 1 instance share
// the stimulus; each phase checks the instance whose behaviour it targets.
module tb_bft_root_buf;
    localparam int CH    = 4;
    localparam int P_W   = 40;
    localparam int DEPTH = 4;
    localparam int W     = CH * P_W;
`ifdef BFT_ROOT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic           ce;
    logic [W-1:0]   up_i;
    logic [P_W-1:0] inj_i;
    logic           inj_valid;

    logic [W-1:0]   dn0, dn1;
    logic           rdy0, rdy1, ovf0, ovf1;
    logic [31:0]    icnt0, rcnt0, icnt1, rcnt1;

    int n_cmp = 0;
    int n_mis = 0;
    int seen  = 0;
    int ch0_tab [12] = '{100, 0, 1, 2, 104, 3, 4, 5, 108, 6, 7, 8};
    logic [W-1:0] e_dn;

    always #5 clk = ~clk;

    bft_root_buf #(.CH(CH), .D_W(32), .P_W(P_W), .DEPTH(DEPTH),
                   .MODE(bft_pkg::MODE_RECIRC_FIRST)) u_m0 (
        .clk(clk), .rst(rst), .ce(ce), .up_i(up_i), .dn_o(dn0),
        .inj_i(inj_i), .inj_valid(inj_valid), .inj_ready(rdy0),
        .ovf(ovf0), .inj_cnt(icnt0), .recirc_cnt(rcnt0));

    bft_root_buf #(.CH(CH), .D_W(32), .P_W(P_W), .DEPTH(DEPTH),
                   .MODE(bft_pkg::MODE_INJ_FIRST)) u_m1 (
        .clk(clk), .rst(rst), .ce(ce), .up_i(up_i), .dn_o(dn1),
        .inj_i(inj_i), .inj_valid(inj_valid), .inj_ready(rdy1),
        .ovf(ovf1), .inj_cnt(icnt1), .recirc_cnt(rcnt1));

    function automatic logic [P_W-1:0] pa(input int n);
        return 40'h80_A000_0000 + 40'(n);
    endfunction
    function automatic logic [P_W-1:0] pb_in(input int n);
        return 40'h00_B000_0000 + 40'(n);
    endfunction
    function automatic logic [P_W-1:0] pb_out(input int n);
        return 40'h80_B000_0000 + 40'(n);
    endfunction
    function automatic logic [W-1:0] place(input logic [P_W-1:0] p, input int ch);
        logic [W-1:0] v;
        v = '0;
        v[ch*P_W +: P_W] = p;
        return v;
    endfunction
    function automatic logic [31:0] stat(input int v);
        return STATS ? 32'(v) : 32'd0;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; inj_valid = 1'b0; inj_i = '0; up_i = '0;

        // Reset held 3 cycles with random traffic
        repeat (3) begin
            up_i = {$urandom, $urandom, $urandom, $urandom, $urandom};
            tick();
        end
        chk("rst_dn0", dn0, '0);
        chk("rst_dn1", dn1, '0);
        chk("rst_rdy0", W'(rdy0), '0);
        chk("rst_rdy1", W'(rdy1), '0);
        chk("rst_ovf0", W'(ovf0), '0);

        rst = 1'b0; up_i = '0;
        #1;
        chk("idle_rdy0", W'(rdy0), W'(1));
        chk("idle_rdy1", W'(rdy1), W'(1));

        // Recirculation: single packet on channel 2
        up_i = place(40'h80_0000_0ABC, 2);
        #1;
        chk("recirc_rdy0", W'(rdy0), W'(1));
        tick();
        chk("recirc_dn0", dn0, place(40'h80_0000_0ABC, 2));
        chk("recirc_dn1", dn1, place(40'h80_0000_0ABC, 2));
        chk("recirc_cnt0", W'(rcnt0), W'(stat(1)));
        up_i = '0;
        tick();
        chk("recirc_idle_dn0", dn0, '0);

        // Round-robin injection, MODE 0, valid bit forced on output
        for (int k = 0; k < 5; k++) begin
            inj_valid = 1'b1;
            inj_i = pb_in(k);
            #1;
            chk("rr_rdy0", W'(rdy0), W'(1));
            tick();
            chk("rr_dn0", dn0, place(pb_out(k), k % 4));
        end
        inj_valid = 1'b0;
        chk("rr_icnt0", W'(icnt0), W'(stat(5)));

        rst = 1'b1;
        tick();
        chk("rst2_icnt0", W'(icnt0), '0);
        chk("rst2_rcnt0", W'(rcnt0), '0);
        rst = 1'b0;

        // MODE 1: continuous channel-0 traffic plus continuous injection
        for (int n = 0; n < 12; n++) begin
            up_i = place(pa(n), 0);
            inj_valid = 1'b1;
            inj_i = pb_in(n);
            #1;
            chk("m1_rdy", W'(rdy1), W'(n <= 8));
            tick();
            e_dn = (ch0_tab[n] >= 100) ? place(pb_out(ch0_tab[n] - 100), 0) : place(pa(ch0_tab[n]), 0);
            if (n <= 8 && (n % 4) != 0) e_dn = e_dn | place(pb_out(n), n % 4);
            chk("m1_dn", dn1, e_dn);
            for (int c = 0; c < CH; c++) seen += int'(dn1[c*P_W + P_W - 1]);
        end
        chk("m1_ovf", W'(ovf1), '0);

        // Clock-enable low for 4 cycles with traffic still presented
        ce = 1'b0;
        for (int n = 12; n < 16; n++) begin
            up_i = place(pa(n), 0);
            inj_i = pb_in(n);
            #1;
            chk("ce_rdy1", W'(rdy1), '0);
            tick();
            chk("ce_dn1", dn1, place(pa(8), 0));
        end

        // Drain: queued entries must be exactly the ones held across ce low
        ce = 1'b1; up_i = '0; inj_valid = 1'b0;
        for (int d = 0; d < 4; d++) begin
            tick();
            chk("drain_dn1", dn1, (d < 3) ? place(pa(9 + d), 0) : '0);
            for (int c = 0; c < CH; c++) seen += int'(dn1[c*P_W + P_W - 1]);
        end
        chk("m1_total", W'(seen), W'(21));
        chk("m1_ovf_end", W'(ovf1), '0);
        chk("m1_icnt", W'(icnt1), W'(stat(9)));
        chk("m1_rcnt", W'(rcnt1), W'(stat(12)));

        // Queue two entries in FIFO 0, then reset mid-operation
        for (int n = 0; n < 8; n++) begin
            up_i = place(pa(20 + n), 0);
            inj_valid = 1'b1;
            inj_i = pb_in(20 + n);
            tick();
        end
        rst = 1'b1; up_i = '0; inj_valid = 1'b0;
        tick();
        chk("mrst_dn1", dn1, '0);
        chk("mrst_rdy1", W'(rdy1), '0);
        chk("mrst_icnt1", W'(icnt1), '0);
        chk("mrst_rcnt1", W'(rcnt1), '0);
        rst = 1'b0;
        #1;
        chk("mrst_rdy1_rel", W'(rdy1), W'(1));
        tick();
        chk("mrst_flush_a", dn1, '0);
        tick();
        chk("mrst_flush_b", dn1, '0);
        chk("final_ovf0", W'(ovf0), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
